// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
//   Shared types and constants for the UART transmit path.
//   - UART_DATA_WIDTH : byte width expected by uart_tx
//   - tx_state_e      : drain sequencer states of uart_tx_fifo
// ----------------------------------------------------------------------------
package uart_pkg;

  localparam int UART_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_DONE = 2'd2
  } tx_state_e;

endpackage

// File: rtl/uart_fifo_mem.sv
// ----------------------------------------------------------------------------
// uart_fifo_mem
//   2**ADDR_WIDTH x DATA_WIDTH register array for the transmit FIFO.
//   One synchronous write port, one asynchronous read port. The array is not
//   reset; validity of entries is tracked by the owner's pointers and count.
// Ports
//   i_SysClock : clock, rising edge
//   i_WrEn     : write enable
//   i_WrAddr   : write address
//   i_WrData   : write data
//   i_RdAddr   : read address
//   o_RdData   : read data, combinational from i_RdAddr
// ----------------------------------------------------------------------------
module uart_fifo_mem #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  i_SysClock,
  input  logic                  i_WrEn,
  input  logic [ADDR_WIDTH-1:0] i_WrAddr,
  input  logic [DATA_WIDTH-1:0] i_WrData,
  input  logic [ADDR_WIDTH-1:0] i_RdAddr,
  output logic [DATA_WIDTH-1:0] o_RdData
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (i_WrEn) begin
      mem_d[i_WrAddr] = i_WrData;
    end
  end

  always_ff @(posedge i_SysClock) begin
    mem_q <= mem_d;
  end

  assign o_RdData = mem_q[i_RdAddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// ----------------------------------------------------------------------------
// uart_tx_fifo
//   Byte buffer and drain sequencer in front of uart_tx. Producers push bytes
//   at clock rate; the sequencer pops one byte, launches it with a one-cycle
//   valid pulse and waits for uart_tx's done pulse before the next launch.
//
// Optional build macro
//   UART_TX_FIFO_COUNT_EN : adds output o_Count (current fill level).
//
// Ports
//   i_SysClock : system clock, rising edge
//   i_Reset    : synchronous, active-high reset
//   i_WrValid  : push request
//   i_WrByte   : push data, taken when i_WrValid && o_WrReady
//   o_WrReady  : FIFO not full (from registered count)
//   o_Overflow : sticky, set after a push attempt while full
//   o_TxValid  : one-cycle launch pulse to uart_tx
//   o_TxByte   : byte to uart_tx, held from launch to next launch
//   i_TxDone   : uart_tx end-of-frame pulse
//   o_Busy     : FIFO non-empty or a byte in flight
//   o_Count    : fill level (UART_TX_FIFO_COUNT_EN only)
//
// State   | meaning
// --------+-------------------------------------------------------------
// IDLE    | nothing in flight; launch as soon as the FIFO is non-empty
// SEND    | launch cycle, o_TxValid high
// WAIT_DONE | byte in flight; on i_TxDone launch next or return to IDLE
// ----------------------------------------------------------------------------
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = UART_DATA_WIDTH
) (
  input  logic                  i_SysClock,
  input  logic                  i_Reset,
  input  logic                  i_WrValid,
  input  logic [DATA_WIDTH-1:0] i_WrByte,
  output logic                  o_WrReady,
  output logic                  o_Overflow,
  output logic                  o_TxValid,
  output logic [DATA_WIDTH-1:0] o_TxByte,
  input  logic                  i_TxDone,
  output logic                  o_Busy
`ifdef UART_TX_FIFO_COUNT_EN
  ,
  output logic [ADDR_WIDTH:0]   o_Count
`endif
);

  localparam logic [ADDR_WIDTH:0] FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};

  tx_state_e             state_q,    state_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q,   wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q,   rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q,    count_d;
  logic                  tx_valid_q, tx_valid_d;
  logic [DATA_WIDTH-1:0] tx_byte_q,  tx_byte_d;
  logic                  overflow_q, overflow_d;

  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] head_byte;

  assign full  = (count_q == FULL_COUNT);
  assign empty = (count_q == '0);
  // Readiness comes from the registered count only, so a pop in the same
  // cycle never opens a slot for a push into a full FIFO.
  assign push  = i_WrValid && !full;

  uart_fifo_mem #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mem (
    .i_SysClock (i_SysClock),
    .i_WrEn     (push),
    .i_WrAddr   (wr_ptr_q),
    .i_WrData   (i_WrByte),
    .i_RdAddr   (rd_ptr_q),
    .o_RdData   (head_byte)
  );

  always_comb begin
    state_d    = state_q;
    tx_valid_d = 1'b0;
    tx_byte_d  = tx_byte_q;
    pop        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (i_TxDone) begin
          if (!empty) begin
            pop     = 1'b1;
            state_d = SEND;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Every pop is a launch: the popped head becomes the byte on the line.
    if (pop) begin
      tx_valid_d = 1'b1;
      tx_byte_d  = head_byte;
    end
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q || (i_WrValid && full);

    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_SysClock) begin
    if (i_Reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      tx_valid_q <= 1'b0;
      tx_byte_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      tx_valid_q <= tx_valid_d;
      tx_byte_q  <= tx_byte_d;
      overflow_q <= overflow_d;
    end
  end

  assign o_WrReady  = !full;
  assign o_Overflow = overflow_q;
  assign o_TxValid  = tx_valid_q;
  assign o_TxByte   = tx_byte_q;
  assign o_Busy     = !empty || (state_q != IDLE);

`ifdef UART_TX_FIFO_COUNT_EN
  assign o_Count = count_q;
`endif

endmodule
